// File: rtl/softmax_writeback.sv
// softmax_writeback: final stage of the softmax pipeline.
//   Packs each accepted group {outp3,outp2,outp1,outp0} (outp0 in the LSBs) into
//   one word, buffers it in a small FIFO and writes it to the result RAM at
//   base_addr, base_addr+1, ... (wrapping modulo 2^ADDRSIZE). Pulses done once
//   addr_limit words have been written.
// Ports:
//   clk, reset (async, active-low)
//   start, base_addr, addr_limit    run control, sampled in IDLE only
//   in_valid/in_ready, outp0..outp3 input group handshake
//   mem_ready, wr_en, wr_addr, wr_data  RAM write port
//   busy, done, nan_seen            status
// Optional feature: define SOFTMAX_WB_NAN_FLAG_EN to build the sticky fp16
//   NaN/Inf detector behind nan_seen; otherwise nan_seen is tied low.
module softmax_writeback #(
   parameter int unsigned DATAWIDTH  = 16,
   parameter int unsigned NUM        = 4,
   parameter int unsigned ADDRSIZE   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADDRSIZE-1:0]       base_addr,
   input  logic [ADDRSIZE-1:0]       addr_limit,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATAWIDTH-1:0]      outp0,
   input  logic [DATAWIDTH-1:0]      outp1,
   input  logic [DATAWIDTH-1:0]      outp2,
   input  logic [DATAWIDTH-1:0]      outp3,
   input  logic                      mem_ready,
   output logic                      wr_en,
   output logic [ADDRSIZE-1:0]       wr_addr,
   output logic [DATAWIDTH*NUM-1:0]  wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      nan_seen
);

   localparam int unsigned WORDW = DATAWIDTH * NUM;
   localparam int unsigned PTRW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW  = ADDRSIZE + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [ADDRSIZE-1:0] base_q;
   logic [CNTW-1:0]     limit_q;
   logic [CNTW-1:0]     acc_cnt;
   logic [CNTW-1:0]     wr_cnt;
   logic [WORDW-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTRW:0]       wr_ptr;
   logic [PTRW:0]       rd_ptr;
   logic                fifo_empty;
   logic                fifo_full;
   logic                push;
   logic                pop;
   logic                start_acc;
   logic [WORDW-1:0]    pack_word;

   // FIFO status from pointers carrying one extra wrap bit
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTRW] != rd_ptr[PTRW]) &&
                       (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);

   assign pack_word = WORDW'({outp3, outp2, outp1, outp0});
   assign start_acc = (state == S_IDLE) && start;
   assign push      = in_valid && in_ready;
   assign pop       = wr_en;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (addr_limit == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            // Leave RUN in the same cycle as the final push
            if (push && ((acc_cnt + CNTW'(1)) == limit_q)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (wr_cnt == limit_q) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode; wr_en is combinational on mem_ready so the grant is used in-cycle
   always_comb begin
      in_ready = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_RUN: begin
            busy     = 1'b1;
            in_ready = !fifo_full && (acc_cnt < limit_q);
            wr_en    = !fifo_empty && mem_ready;
         end
         S_DRAIN: begin
            busy  = 1'b1;
            wr_en = !fifo_empty && mem_ready;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign wr_data = fifo_mem[rd_ptr[PTRW-1:0]];
   assign wr_addr = base_q + wr_cnt[ADDRSIZE-1:0];

   // Run parameters and progress counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q  <= '0;
         limit_q <= '0;
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else if (start_acc) begin
         base_q  <= base_addr;
         limit_q <= CNTW'(addr_limit);
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else begin
         if (push) acc_cnt <= acc_cnt + CNTW'(1);
         if (pop)  wr_cnt  <= wr_cnt + CNTW'(1);
      end
   end

   // Word FIFO; storage is reset so wr_data reads zero out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr[PTRW-1:0]] <= pack_word;
            wr_ptr <= wr_ptr + (PTRW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (PTRW+1)'(1);
      end
   end

`ifdef SOFTMAX_WB_NAN_FLAG_EN
   logic nan_q;
   logic nan_hit;

   // Exponent all-ones marks fp16 NaN or Inf
   assign nan_hit = (outp0[14:10] == 5'h1F) || (outp1[14:10] == 5'h1F) ||
                    (outp2[14:10] == 5'h1F) || (outp3[14:10] == 5'h1F);

   // Sticky flag, cleared only by an accepted start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                nan_q <= 1'b0;
      else if (start_acc)        nan_q <= 1'b0;
      else if (push && nan_hit)  nan_q <= 1'b1;
   end

   assign nan_seen = nan_q;
`else
   assign nan_seen = 1'b0;
`endif

endmodule
